// File: rtl/parity_serial_tx.sv
// parity_serial_tx: serializes start, 4 data bits LSB-first, even/odd parity and stop at CLKS_PER_BIT clocks per bit
module parity_serial_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_in,
  input  logic       parity_type,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       parity_bit,
  output logic       frame_done
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE = CW'(CLKS_PER_BIT - 2);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] shift;
  logic [1:0] idx;
  logic bit_end;
  assign bit_end = cnt == LAST;
  assign in_ready = state == IDLE && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx_out <= 1'b1;
      busy <= 1'b0;
      parity_bit <= 1'b0;
      frame_done <= 1'b0;
      shift <= '0;
      cnt <= '0;
      idx <= '0;
    end else begin
      frame_done <= 1'b0;
      cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (in_valid && in_ready) begin
          state <= START;
          tx_out <= 1'b0;
          busy <= 1'b1;
          shift <= data_in;
          parity_bit <= ^data_in ^ parity_type;
        end
        START: if (bit_end) begin
          state <= DATA;
          tx_out <= shift[0];
          idx <= '0;
        end
        DATA: if (bit_end) begin
          if (idx == 2'd3) begin
            state <= PARITY;
            tx_out <= parity_bit;
          end else begin
            shift <= shift >> 1;
            tx_out <= shift[1];
            idx <= idx + 1'b1;
          end
        end
        PARITY: if (bit_end) begin
          state <= STOP;
          tx_out <= 1'b1;
          frame_done <= CLKS_PER_BIT == 1;
        end
        STOP: if (bit_end) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          frame_done <= cnt == PRE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_parity_serial_tx.sv
// tb_parity_serial_tx: frame-level model plus directed frames for CLKS_PER_BIT of 4 and 1
module tb_parity_serial_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v4 = 1'b0, v1 = 1'b0, pt4 = 1'b0, pt1 = 1'b0;
  logic [3:0] d4 = '0, d1 = '0;
  logic [1:0] tx, bsy, pb, fd, rdy;
  int cmp = 0, err = 0;
  int rem [2] = '{0, 0};
  logic [6:0] bits [2];
  logic par [2] = '{1'b0, 1'b0};
  logic live = 1'b0;
  always #5 clk = ~clk;
  parity_serial_tx #(.CLKS_PER_BIT(4)) u4 (.clk(clk), .rst(rst), .data_in(d4), .parity_type(pt4),
    .in_valid(v4), .in_ready(rdy[0]), .tx_out(tx[0]), .busy(bsy[0]), .parity_bit(pb[0]), .frame_done(fd[0]));
  parity_serial_tx #(.CLKS_PER_BIT(1)) u1 (.clk(clk), .rst(rst), .data_in(d1), .parity_type(pt1),
    .in_valid(v1), .in_ready(rdy[1]), .tx_out(tx[1]), .busy(bsy[1]), .parity_bit(pb[1]), .frame_done(fd[1]));
  function automatic int cpbof(input int i);
    return i == 0 ? 4 : 1;
  endfunction
  function automatic logic fpar(input logic [3:0] d, input logic odd);
    return logic'($countones(d) % 2) ^ odd;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        rem[i] <= 0;
        par[i] <= 1'b0;
        live <= 1'b1;
      end else if (rem[i] > 0) begin
        rem[i] <= rem[i] - 1;
      end else if (i == 0 ? v4 : v1) begin
        rem[i] <= 7 * cpbof(i);
        par[i] <= fpar(i == 0 ? d4 : d1, i == 0 ? pt4 : pt1);
        bits[i] <= {1'b1, fpar(i == 0 ? d4 : d1, i == 0 ? pt4 : pt1), (i == 0 ? d4 : d1), 1'b0};
      end
    end
  end
  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("tx%0d", i), 32'(tx[i]), 32'(rem[i] == 0 ? 1'b1 : bits[i][(7 * cpbof(i) - rem[i]) / cpbof(i)]));
        chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(rem[i] > 0));
        chk($sformatf("done%0d", i), 32'(fd[i]), 32'(rem[i] == 1));
        chk($sformatf("par%0d", i), 32'(pb[i]), 32'(par[i]));
        chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(rem[i] == 0 && !rst));
      end
    end
  end
  task automatic accept4(input logic [3:0] d, input logic p, input bit hold, output int waits);
    d4 = d;
    pt4 = p;
    v4 = 1'b1;
    waits = 0;
    do begin
      @(posedge clk);
      #1;
      waits++;
    end while (rem[0] != 28 && waits < 100);
    if (waits >= 100) chk("accept_timeout", 32'(waits), 32'(0));
    if (!hold) v4 = 1'b0;
  endtask
  task automatic frame4(input string name, input logic [3:0] d, input logic p, input bit hold,
                        input logic [6:0] exp_line, input logic exp_p, output int waits);
    logic [6:0] line;
    int fdc, fdn, rc;
    accept4(d, p, hold, waits);
    line = '0;
    fdc = 0;
    fdn = 0;
    rc = 0;
    for (int j = 1; j <= 28; j++) begin
      @(negedge clk);
      if ((j - 1) % 4 == 1) line[6 - (j - 1) / 4] = tx[0];
      if (fd[0]) begin
        fdc = j;
        fdn++;
      end
      if (rdy[0]) rc++;
      if (hold && j == 2) d4 = 4'b0110;
      if (hold && j == 20) d4 = 4'b1111;
    end
    chk({name, "_line"}, 32'(line), 32'(exp_line));
    chk({name, "_parity"}, 32'(pb[0]), 32'(exp_p));
    chk({name, "_done_cycle"}, 32'(fdc), 32'(28));
    chk({name, "_done_count"}, 32'(fdn), 32'(1));
    chk({name, "_ready_cycles"}, 32'(rc), 32'(0));
  endtask
  initial begin
    int w;
    logic [6:0] line;
    int fdc;
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(tx[0]), 32'(1));
    chk("rst_busy", 32'(bsy[0]), 32'(0));
    chk("rst_parity", 32'(pb[0]), 32'(0));
    chk("rst_done", 32'(fd[0]), 32'(0));
    chk("rst_ready", 32'(rdy[0]), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(rdy[0]), 32'(1));
    frame4("even1011", 4'b1011, 1'b0, 0, 7'b0110111, 1'b1, w);
    frame4("odd1011", 4'b1011, 1'b1, 0, 7'b0110101, 1'b0, w);
    frame4("even0000", 4'b0000, 1'b0, 0, 7'b0000001, 1'b0, w);
    frame4("odd0000", 4'b0000, 1'b1, 0, 7'b0000011, 1'b1, w);
    frame4("busy_f1", 4'b1011, 1'b0, 1, 7'b0110111, 1'b1, w);
    frame4("busy_f2", d4, pt4, 0, 7'b0111101, 1'b0, w);
    chk("busy_gap_edges", 32'(w), 32'(2));
    accept4(4'b1011, 1'b0, 0, w);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", 32'(tx[0]), 32'(1));
    chk("midrst_busy", 32'(bsy[0]), 32'(0));
    chk("midrst_parity", 32'(pb[0]), 32'(0));
    chk("midrst_done", 32'(fd[0]), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(rdy[0]), 32'(1));
    frame4("odd0001", 4'b0001, 1'b1, 0, 7'b0100001, 1'b0, w);
    d1 = 4'b1000;
    pt1 = 1'b0;
    v1 = 1'b1;
    w = 0;
    do begin
      @(posedge clk);
      #1;
      w++;
    end while (rem[1] != 7 && w < 100);
    if (w >= 100) chk("cpb1_accept_timeout", 32'(w), 32'(0));
    v1 = 1'b0;
    line = '0;
    fdc = 0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j <= 7) line[7 - j] = tx[1];
      if (fd[1]) fdc = j;
      if (j == 7) chk("cpb1_parity", 32'(pb[1]), 32'(1));
      if (j == 8) chk("cpb1_ready", 32'(rdy[1]), 32'(1));
    end
    chk("cpb1_line", 32'(line), 32'(7'b0000111));
    chk("cpb1_done_cycle", 32'(fdc), 32'(7));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/parity_serial_tx.md
# parity_serial_tx

Transmit-side counterpart of the 4-bit parity checker. Accepts a 4-bit nibble and a parity-type select over a valid/ready handshake, generates the even or odd parity bit, and serializes a frame (start, 4 data bits LSB-first, parity, stop) onto a single line, one bit every `CLKS_PER_BIT` clocks. The receiving end recovers `data_in`, `parity_bit` and `parity_type` and feeds the parity checker, which flags `error`.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range 1..65535, counter width is `$clog2(CLKS_PER_BIT+1)`, minimum 1 bit.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `data_in`  in  4  nibble to send; sampled on the accept edge.
- `parity_type`  in  1  0 = even, 1 = odd; sampled on the accept edge.
- `in_valid`  in  1  `data_in`/`parity_type` are valid.
- `in_ready`  out  1  block can accept; combinational, equals (state == IDLE) && !rst.
- `tx_out`  out  1  serial line, registered; idles high.
- `busy`  out  1  registered; 1 in every state except IDLE.
- `parity_bit`  out  1  registered parity of the frame in flight (held after the frame until the next accept).
- `frame_done`  out  1  registered one-cycle pulse during the final cycle of the stop bit.

## Operation
- Accept: rising edge with `in_valid && in_ready`. The block latches `data_in` into the shift register and computes `parity_bit = ^data_in ^ parity_type`. Example: 1011 gives parity 1 for even and 0 for odd. 0000 gives 0 for even and 1 for odd.
- States and transitions:
  - IDLE: `tx_out`=1. Goes to START on accept.
  - START: `tx_out`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: `tx_out` = shift[0]; shifts right every `CLKS_PER_BIT` cycles; a 2-bit index counts 0..3. Goes to PARITY after bit 3.
  - PARITY: `tx_out` = `parity_bit` for `CLKS_PER_BIT` cycles, then STOP.
  - STOP: `tx_out`=1 for `CLKS_PER_BIT` cycles. `frame_done`=1 in the last of these cycles, then IDLE.
- Baud counter: reloads to 0 on every state/bit change and increments each cycle. A bit ends when count == `CLKS_PER_BIT`-1.
- Inputs are ignored outside the accept edge. Changing `data_in` mid-frame has no effect.
- Simultaneous `frame_done` and new `in_valid`: no accept in that cycle, because the state is still STOP. Accept happens in the following IDLE cycle at the earliest.
- Reset, any cycle including mid-frame: on the next edge the state goes to IDLE, `tx_out`=1, `busy`=0, `frame_done`=0, `parity_bit`=0, and the shift register and counters are cleared. A partially sent frame is abandoned with no `frame_done`.

## Timing
- Reset values: `tx_out`=1, `busy`=0, `parity_bit`=0, `frame_done`=0. `in_ready`=0 while `rst`=1 and 1 in the first cycle after.
- Accept on edge k: from edge k+1, `tx_out`=0 and `busy`=1.
- Bit n of the frame (n = 0..6: start, d0, d1, d2, d3, parity, stop) occupies cycles k+1+n·`CLKS_PER_BIT` through k+(n+1)·`CLKS_PER_BIT`.
- `frame_done` is high in cycle k+7·`CLKS_PER_BIT`.
- IDLE is re-entered at k+7·`CLKS_PER_BIT`+1, where `in_ready`=1 and `busy`=0.
- Back-to-back frames: minimum frame period is 7·`CLKS_PER_BIT`+1 cycles, with exactly one idle-high cycle between the stop bit and the next start bit.

## Test plan
1. Even frame: `CLKS_PER_BIT`=4, `parity_type`=0, `data_in`=1011, accept.
   - `tx_out` sequence, each level 4 cycles: 0,1,1,0,1,1,1.
   - `parity_bit`=1.
   - `frame_done` pulses 28 cycles after accept.
2. Odd frame: `parity_type`=1, `data_in`=1011.
   - `tx_out` sequence: 0,1,1,0,1,0,1.
   - `parity_bit`=0.
3. Zero data:
   - `data_in`=0000, even: parity slot 0, line low for 24 cycles.
   - `data_in`=0000, odd: parity slot 1.
4. Busy handling:
   - Hold `in_valid`=1 continuously with `data_in`=0110 during frame 1, then 1111.
   - `in_ready`=0 for the 28 frame cycles, and frame 1 carries 1011.
   - Frame 2 starts after one idle-high cycle and carries 1111 with even parity 0.
5. Reset mid-frame: assert `rst` for one cycle during d2 of a frame.
   - Next edge: `tx_out`=1, `busy`=0, `parity_bit`=0, no `frame_done`.
   - `in_ready`=1 the cycle after `rst` drops.
   - A new 0001 odd frame sends parity 0.
6. `CLKS_PER_BIT`=1, `data_in`=1000, even.
   - `tx_out` sequence: 0,0,0,0,1,1,1, one cycle each.
   - `frame_done` 7 cycles after accept, `in_ready` at cycle 8.
